// File: rtl/audio_tx_buffer.sv
// ============================================================================
// audio_tx_buffer: prefilling FIFO (first-word-fall-through) feeding the codec write port
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_tx_buffer #(
  parameter int W           = 24,
  parameter int DEPTH       = 16,
  parameter int START_LEVEL = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     isValid,
  input  logic [W-1:0]             dataInLeft,
  input  logic [W-1:0]             dataInRight,
  input  logic                     write_ready,
  output logic                     write,
  output logic [W-1:0]             writedata_left,
  output logic [W-1:0]             writedata_right,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic [7:0]               underflow_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_START = CW'(START_LEVEL);

  typedef enum logic [0:0] {
    S_FILL   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [W-1:0]    r_mem_l [DEPTH];
  logic [W-1:0]    r_mem_r [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_next;
  logic            r_overflow;
  logic [7:0]      r_ucnt;
  logic            w_push;
  logic            w_drop;
  logic            w_pop;
  logic            w_underflow;

  // Full check uses the pre-edge occupancy, so a same-cycle pop never frees a slot
  assign w_push       = isValid && (r_count != C_DEPTH);
  assign w_drop       = isValid && (r_count == C_DEPTH);
  assign w_pop        = (r_state == S_STREAM) && (r_count != '0) && write_ready;
  assign w_underflow  = (r_state == S_STREAM) && (r_count == '0) && write_ready;
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FILL:   if (w_count_next >= C_START) w_state_next = S_STREAM;
      S_STREAM: if (w_underflow)             w_state_next = S_FILL;
      default:  w_state_next = S_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_FILL;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_ucnt     <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_drop) r_overflow <= 1'b1;
      if (w_underflow && (r_ucnt != 8'hFF)) r_ucnt <= r_ucnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_l[r_wr_ptr] <= dataInLeft;
      r_mem_r[r_wr_ptr] <= dataInRight;
    end
  end

  assign write           = w_pop;
  assign writedata_left  = (r_count != '0) ? r_mem_l[r_rd_ptr] : '0;
  assign writedata_right = (r_count != '0) ? r_mem_r[r_rd_ptr] : '0;
  assign count           = r_count;
  assign full            = (r_count == C_DEPTH);
  assign overflow        = r_overflow;
  assign underflow_cnt   = r_ucnt;

endmodule

`default_nettype wire

// File: tb/tb_audio_tx_buffer.sv
// ============================================================================
// tb_audio_tx_buffer: queue-based reference model and scoreboard for audio_tx_buffer
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_audio_tx_buffer;

  localparam int W     = 24;
  localparam int DEPTH = 16;
  localparam int START = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           isValid;
  logic           write_ready;
  logic [W-1:0]   dl;
  logic [W-1:0]   dr;
  logic           write;
  logic [W-1:0]   wdl;
  logic [W-1:0]   wdr;
  logic [4:0]     count;
  logic           full;
  logic           overflow;
  logic [7:0]     underflow_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [W-1:0] l;
    logic [W-1:0] r;
  } pair_t;

  pair_t sb[$];
  bit    m_stream = 1'b0;
  bit    m_ovf    = 1'b0;
  int    m_ucnt   = 0;

  audio_tx_buffer #(.W(W), .DEPTH(DEPTH), .START_LEVEL(START)) dut (
    .clk             (clk),
    .reset           (reset),
    .isValid         (isValid),
    .dataInLeft      (dl),
    .dataInRight     (dr),
    .write_ready     (write_ready),
    .write           (write),
    .writedata_left  (wdl),
    .writedata_right (wdr),
    .count           (count),
    .full            (full),
    .overflow        (overflow),
    .underflow_cnt   (underflow_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare at negedge, then advance the model by the effect of the coming edge
  always @(negedge clk) begin : mon
    int    sz;
    bit    exp_w;
    bit    acc;
    pair_t p;
    if (reset) begin
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_write", 64'(write), 64'd0);
      chk("rst_wdl", 64'(wdl), 64'd0);
      chk("rst_wdr", 64'(wdr), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      chk("rst_ucnt", 64'(underflow_cnt), 64'd0);
      sb.delete();
      m_stream = 1'b0;
      m_ovf    = 1'b0;
      m_ucnt   = 0;
    end else begin
      sz    = sb.size();
      exp_w = m_stream && (sz != 0) && write_ready;
      chk("write", 64'(write), 64'(exp_w));
      chk("count", 64'(count), 64'(sz));
      chk("full", 64'(full), 64'(sz == DEPTH));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("ucnt", 64'(underflow_cnt), 64'(m_ucnt));
      chk("wdl", 64'(wdl), (sz != 0) ? 64'(sb[0].l) : 64'd0);
      chk("wdr", 64'(wdr), (sz != 0) ? 64'(sb[0].r) : 64'd0);
      acc = isValid && (sz < DEPTH);
      if (isValid && !acc) m_ovf = 1'b1;
      if (exp_w) void'(sb.pop_front());
      if (acc) begin
        p.l = dl;
        p.r = dr;
        sb.push_back(p);
      end
      if (!m_stream) begin
        if (sb.size() >= START) m_stream = 1'b1;
      end else if (write_ready && sz == 0) begin
        m_stream = 1'b0;
        if (m_ucnt < 255) m_ucnt++;
      end
    end
  end

  task automatic step(input bit v, input logic [W-1:0] l, input logic [W-1:0] r, input bit wr);
    isValid     = v;
    dl          = l;
    dr          = r;
    write_ready = wr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    step(1'b1, 24'd7, 24'd9, 1'b1);
    step(1'b1, 24'd7, 24'd9, 1'b1);
    reset = 1'b0;

    // Prefill with (160k, -160k), then drain into an underflow
    for (int k = 1; k <= 8; k++) step(1'b1, W'(160 * k), W'(-160 * k), 1'b1);
    repeat (12) step(1'b0, '0, '0, 1'b1);

    // Backpressure: 20 offered, 16 kept
    for (int k = 1; k <= 20; k++) step(1'b1, W'($urandom), W'($urandom), 1'b0);
    step(1'b1, W'(1000), W'(-1000), 1'b1);
    repeat (10) step(1'b0, '0, '0, 1'b1);
    repeat (4) step(1'b1, W'($urandom), W'($urandom), 1'b1);
    repeat (5) step(1'b1, W'($urandom), W'($urandom), 1'b0);

    // Asynchronous reset between edges while streaming with 10 entries
    isValid     = 1'b0;
    write_ready = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_write", 64'(write), 64'd0);
    chk("async_rst_wdl", 64'(wdl), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int k = 1; k <= 8; k++) step(1'b1, W'(7 * k), W'(-7 * k), 1'b1);

    for (int seg = 0; seg < 6; seg++) begin
      int pv;
      int pr;
      pv = (seg % 3 == 0) ? 80 : ((seg % 3 == 1) ? 50 : 30);
      pr = (seg % 2 == 0) ? 40 : 75;
      repeat (400) step($urandom_range(0, 99) < pv, W'($urandom), W'($urandom),
                        $urandom_range(0, 99) < pr);
    end
    repeat (3) step(1'b0, '0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/audio_tx_buffer.md
Name: audio_tx_buffer

Overview:
- Output-side elastic buffer for the lab 3 audio path. It accepts filtered left/right 24-bit samples from the FIR stage (isValid/dataIn style producer) and drains them to the audio codec write port using the codec's write_ready/write handshake.
- Prefills to a threshold before streaming, so codec jitter does not cause immediate underflow.
- Flags overflow and counts underflow events.

Parameters:
- W, 24, sample width in bits (signed two's complement).
- DEPTH, 16, FIFO depth in stereo sample pairs; power of two, at least 4.
- START_LEVEL, 8, occupancy required before streaming starts or resumes; 1 ≤ START_LEVEL ≤ DEPTH.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- isValid  input  1  one stereo sample pair offered this cycle.
- dataInLeft  input  W  left sample, signed.
- dataInRight  input  W  right sample, signed.
- write_ready  input  1  codec can accept a sample pair this cycle.
- write  output  1  sample pair presented; transfer occurs on a rising edge where write && write_ready.
- writedata_left  output  W  left sample to codec.
- writedata_right  output  W  right sample to codec.
- count  output  $clog2(DEPTH)+1  current occupancy.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky: a sample was dropped.
- underflow_cnt  output  8  saturating count of underflow events.

Behaviour:
- Reset (async, any time, including mid-stream):
  - pointers = 0, count = 0, state = FILL.
  - overflow = 0, underflow_cnt = 0, write = 0.
  - writedata_left/right = 0.
  - Memory contents are don't-care.
- Storage: register array, first-word-fall-through. writedata_left/right always show the head entry when count > 0, and 0 when count == 0. Data is passed unmodified; there is no width change.
- Push: on a rising edge with isValid = 1 and pre-edge count < DEPTH, write the pair at wr_ptr, then wr_ptr++ modulo DEPTH.
- Push when full: if pre-edge count == DEPTH, the pair is dropped and overflow is set to 1 until reset. This applies even if a pop happens the same cycle; the full check uses the pre-edge count only.
- Pop: on a rising edge with write && write_ready, rd_ptr++ modulo DEPTH.
- Simultaneous push and pop with count in 1..DEPTH-1: count is unchanged and both pointers advance.
- Count update: count_next = count + push_accepted - pop. Pointers wrap with no extra state.
- write is combinational: write = (state == STREAM) && (count != 0) && write_ready.
  - write_ready low: write is 0 and the head entry is held unchanged.
- State machine:
  - FILL: write = 0. Go to STREAM on the edge after which count_next ≥ START_LEVEL.
  - STREAM: drain on each write_ready. If write_ready = 1 while count == 0, that cycle is an underflow:
    - go to FILL,
    - underflow_cnt increments, saturating at 255.
  - Reaching count == 0 through a normal pop is not an underflow. Underflow is detected only when the codec requests data from an empty buffer.
- Latency: a pair pushed into an empty buffer while in STREAM appears on writedata on the next cycle. Minimum input-to-codec latency is 1 clock.
- Ordering: strict FIFO. Left and right samples of a pair always travel together.

Test Plan:
- Reset values: hold reset 2 cycles with isValid = 1 and write_ready = 1. Required: count = 0, write = 0, writedata = 0, overflow = 0, underflow_cnt = 0, and nothing is stored.
- Prefill:
  - With write_ready = 1, push pairs (L,R) = (160,-160), (320,-320), ... (8 pairs). Required: write = 0 through the first 7 pushes.
  - After the 8th edge: write = 1 with writedata = (160,-160).
  - Subsequent pops yield 320, 480, ... in order.
- Backpressure and full:
  - With write_ready = 0, push 20 pairs. Required: count saturates at 16, full = 1, overflow = 1, and pairs 17-20 are absent.
  - Raise write_ready: the 16 pairs drain in order.
- Underflow: in STREAM with write_ready = 1 and no pushes, drain to empty; the next cycle is an underflow. Required: underflow_cnt = 1, state returns to FILL, and write stays 0 until 8 new pairs are buffered.
- Simultaneous push and pop: at count = 16 and write_ready = 1, push 1000 in the same cycle as a pop. Required: 1000 is dropped, count = 15, and overflow = 1. At count = 5, push and pop together: count stays 5 and FIFO order is preserved.
- Reset mid-stream: assert reset asynchronously between edges with count = 10. Required: count = 0 and write = 0 immediately, without waiting for a clock edge. After release, FILL behaviour restarts.
